// File: rtl/freq_pkg.sv
// rtl/freq_pkg.sv - shared parameters, complex type and helpers for freq_mac
// Purpose: widths of the frequency-domain MAC datapath, the complex bin type,
//          a saturate-to-width helper and the beat slice-index helper.
// Ports: none (package).
package freq_pkg;

  localparam int DATALEN  = 16;
  localparam int FFTCHNL  = 8;
  localparam int CMPLXLEN = 2 * DATALEN;
  localparam int NBEAT    = 4;
  localparam int FRACBITS = 8;
  localparam int ACCLEN   = 24;

  // Bins carried per beat: two rows of FFTCHNL columns.
  localparam int NBIN    = FFTCHNL * 2;
  localparam int BEATLEN = NBIN * CMPLXLEN;
  localparam int BEATW   = $clog2(NBEAT);

  // Full complex product: two DATALEN x (DATALEN+1) products summed, with
  // headroom for the negated -2^(DATALEN-1) weight in conjugate mode.
  localparam int PRODLEN = 2 * DATALEN + 2;
  localparam int PLEN    = PRODLEN - FRACBITS;
  localparam int SUMLEN  = ((PLEN > ACCLEN) ? PLEN : ACCLEN) + 1;

  // Real part in the low DATALEN bits, imag in the high bits.
  typedef struct packed {
    logic signed [DATALEN-1:0] im;
    logic signed [DATALEN-1:0] re;
  } cmplx_t;

  // Clamp a signed value to the range of a signed 'width'-bit number.
  function automatic logic signed [63:0] sat(input logic signed [63:0] x, input int width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (x > hi)      return hi;
    else if (x < lo) return lo;
    else             return x;
  endfunction

  // LSB of column 'col', slot 'slot' (0: even row, 1: odd row) within a beat.
  function automatic int bin_lsb(input int col, input int slot);
    return (2 * col + slot) * CMPLXLEN;
  endfunction

endpackage

// File: rtl/freq_mac_if.sv
// rtl/freq_mac_if.sv - beat stream bundle between fft2D, freq_mac and the inverse FFT
// Purpose: groups the input beat, kernel beat, channel count and output beat.
// Ports (signals): invalid/indata/inwt/nchnl toward the MAC,
//                  outvalid/outdata/busy from the MAC.
// master: the producer/consumer side (testbench or surrounding pipeline).
// slave : freq_mac.
interface freq_mac_if;
  import freq_pkg::*;

  logic               invalid;
  logic [BEATLEN-1:0] indata;
  logic [BEATLEN-1:0] inwt;
  logic [7:0]         nchnl;
  logic               outvalid;
  logic [BEATLEN-1:0] outdata;
  logic               busy;

  modport master (
    output invalid, indata, inwt, nchnl,
    input  outvalid, outdata, busy
  );

  modport slave (
    input  invalid, indata, inwt, nchnl,
    output outvalid, outdata, busy
  );

endinterface

// File: rtl/cmplx_mul.sv
// rtl/cmplx_mul.sv - one registered fixed-point complex multiply
// Purpose: p = d*w (or d*conj(w) when FREQ_MAC_CONJ_EN is defined), full
//          precision, arithmetic right shift by FRACBITS, registered.
// Ports: clk, rst (async active-high), d data bin, w weight bin,
//        p_re/p_im shifted product (PLEN bits each), one cycle after d/w.
module cmplx_mul
  import freq_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  cmplx_t                 d,
  input  cmplx_t                 w,
  output logic signed [PLEN-1:0] p_re,
  output logic signed [PLEN-1:0] p_im
);

  // One extra bit so that negating -2^(DATALEN-1) does not wrap.
  logic signed [DATALEN:0]    wim;
  logic signed [PRODLEN-1:0]  prod_re;
  logic signed [PRODLEN-1:0]  prod_im;

`ifdef FREQ_MAC_CONJ_EN
  assign wim = -((DATALEN+1)'(w.im));
`else
  assign wim = (DATALEN+1)'(w.im);
`endif

  assign prod_re = PRODLEN'(d.re) * PRODLEN'(w.re) - PRODLEN'(d.im) * PRODLEN'(wim);
  assign prod_im = PRODLEN'(d.re) * PRODLEN'(wim)  + PRODLEN'(d.im) * PRODLEN'(w.re);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_re <= '0;
      p_im <= '0;
    end else begin
      p_re <= PLEN'(prod_re >>> FRACBITS);
      p_im <= PLEN'(prod_im >>> FRACBITS);
    end
  end

endmodule

// File: rtl/freq_mac.sv
// rtl/freq_mac.sv - frequency-domain multiply-accumulate over input-channel tiles
// Purpose: multiplies each fft2D bin by its kernel bin, accumulates per beat
//          over nchnl channel tiles and emits the saturated sum on the final
//          channel, two cycles after each input beat.
// Ports: clk, rst (async active-high), bus (freq_mac_if.slave):
//        invalid/indata/inwt/nchnl in, outvalid/outdata/busy out.
// Build option: FREQ_MAC_CONJ_EN selects d*conj(w) in cmplx_mul.
module freq_mac
  import freq_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  freq_mac_if.slave bus
);

  logic [BEATW-1:0] beat_cnt;
  logic [7:0]       chnl_cnt;
  logic [7:0]       nchnl_q;
  logic [7:0]       n_eff;
  logic             group_start;
  logic             last_beat;
  logic             last_chnl;
  logic             busy_q;

  // On the first beat of a group the live nchnl is used, later beats use
  // the latched copy, so mid-group changes are ignored.
  assign group_start = (beat_cnt == '0) && (chnl_cnt == 8'd0);
  assign n_eff       = group_start ? ((bus.nchnl == 8'd0) ? 8'd1 : bus.nchnl) : nchnl_q;
  assign last_beat   = (beat_cnt == BEATW'(NBEAT - 1));
  assign last_chnl   = (chnl_cnt == (n_eff - 8'd1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt <= '0;
      chnl_cnt <= 8'd0;
      nchnl_q  <= 8'd1;
      busy_q   <= 1'b0;
    end else if (bus.invalid) begin
      if (group_start) nchnl_q <= n_eff;
      busy_q <= !(last_beat && last_chnl);
      if (last_beat) begin
        beat_cnt <= '0;
        chnl_cnt <= last_chnl ? 8'd0 : chnl_cnt + 8'd1;
      end else begin
        beat_cnt <= beat_cnt + BEATW'(1);
      end
    end
  end

  // Beat tags travel alongside the stage-1 products.
  logic             s1_valid;
  logic             s1_first;
  logic             s1_last;
  logic [BEATW-1:0] s1_beat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s1_beat  <= '0;
    end else begin
      s1_valid <= bus.invalid;
      s1_first <= (chnl_cnt == 8'd0);
      s1_last  <= last_chnl;
      s1_beat  <= beat_cnt;
    end
  end

  logic signed [ACCLEN-1:0]  acc_re [NBEAT][NBIN];
  logic signed [ACCLEN-1:0]  acc_im [NBEAT][NBIN];
  logic signed [ACCLEN-1:0]  nxt_re [NBIN];
  logic signed [ACCLEN-1:0]  nxt_im [NBIN];
  logic [NBIN-1:0][CMPLXLEN-1:0] out_nxt;
  logic [BEATLEN-1:0]        out_q;
  logic                      outvalid_q;

  for (genvar i = 0; i < FFTCHNL; i++) begin : g_col
    for (genvar s = 0; s < 2; s++) begin : g_slot
      localparam int J = 2 * i + s;

      cmplx_t                   d;
      cmplx_t                   w;
      cmplx_t                   o;
      logic signed [PLEN-1:0]   p_re;
      logic signed [PLEN-1:0]   p_im;
      logic signed [SUMLEN-1:0] base_re;
      logic signed [SUMLEN-1:0] base_im;
      logic signed [SUMLEN-1:0] sum_re;
      logic signed [SUMLEN-1:0] sum_im;

      assign d = bus.indata[bin_lsb(i, s) +: CMPLXLEN];
      assign w = bus.inwt[bin_lsb(i, s) +: CMPLXLEN];

      cmplx_mul u_mul (
        .clk  (clk),
        .rst  (rst),
        .d    (d),
        .w    (w),
        .p_re (p_re),
        .p_im (p_im)
      );

      // Channel 0 overwrites the beat's accumulator instead of adding to it.
      assign base_re = s1_first ? '0 : SUMLEN'(acc_re[s1_beat][J]);
      assign base_im = s1_first ? '0 : SUMLEN'(acc_im[s1_beat][J]);
      assign sum_re  = base_re + SUMLEN'(p_re);
      assign sum_im  = base_im + SUMLEN'(p_im);
      assign nxt_re[J] = ACCLEN'(sat(64'(sum_re), ACCLEN));
      assign nxt_im[J] = ACCLEN'(sat(64'(sum_im), ACCLEN));

      assign o.re = DATALEN'(sat(64'(nxt_re[J]), DATALEN));
      assign o.im = DATALEN'(sat(64'(nxt_im[J]), DATALEN));
      assign out_nxt[J] = o;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < NBEAT; b++) begin
        for (int j = 0; j < NBIN; j++) begin
          acc_re[b][j] <= '0;
          acc_im[b][j] <= '0;
        end
      end
      outvalid_q <= 1'b0;
      out_q      <= '0;
    end else begin
      if (s1_valid) begin
        for (int j = 0; j < NBIN; j++) begin
          acc_re[s1_beat][j] <= nxt_re[j];
          acc_im[s1_beat][j] <= nxt_im[j];
        end
      end
      outvalid_q <= s1_valid && s1_last;
      if (s1_valid && s1_last) out_q <= out_nxt;
    end
  end

  assign bus.outvalid = outvalid_q;
  assign bus.outdata  = out_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_freq_mac.sv
// tb/tb_freq_mac.sv - self-checking bench for freq_mac
module tb_freq_mac;
  import freq_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  freq_mac_if bus ();

  freq_mac dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [BEATLEN-1:0] act, input logic [BEATLEN-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic longint clampw(input longint x, input int width);
    longint hi;
    longint lo;
    hi = (64'sd1 <<< (width - 1)) - 1;
    lo = -(64'sd1 <<< (width - 1));
    return (x > hi) ? hi : ((x < lo) ? lo : x);
  endfunction

  // Behavioural model: per-beat complex sums kept as plain integers.
  longint             macc_re [NBEAT][NBIN];
  longint             macc_im [NBEAT][NBIN];
  int                 mb, mc, mn;
  logic               ev1_v, ev2_v, ebusy;
  logic [BEATLEN-1:0] ev1_d, ev2_d;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mb = 0; mc = 0; mn = 1;
      ev1_v = 1'b0; ev2_v = 1'b0; ebusy = 1'b0;
      ev1_d = '0; ev2_d = '0;
      for (int b = 0; b < NBEAT; b++)
        for (int j = 0; j < NBIN; j++) begin
          macc_re[b][j] = 0;
          macc_im[b][j] = 0;
        end
    end else begin
      ev2_v = ev1_v;
      ev2_d = ev1_d;
      ev1_v = 1'b0;
      if (bus.invalid) begin
        if (mb == 0 && mc == 0) mn = (bus.nchnl == 0) ? 1 : int'(bus.nchnl);
        for (int j = 0; j < NBIN; j++) begin
          longint dr, di, wr, wi, pr, pi;
          logic [15:0] ore, oim;
          dr = longint'($signed(bus.indata[j*CMPLXLEN +: DATALEN]));
          di = longint'($signed(bus.indata[j*CMPLXLEN+DATALEN +: DATALEN]));
          wr = longint'($signed(bus.inwt[j*CMPLXLEN +: DATALEN]));
          wi = longint'($signed(bus.inwt[j*CMPLXLEN+DATALEN +: DATALEN]));
`ifdef FREQ_MAC_CONJ_EN
          wi = -wi;
`endif
          pr = (dr * wr - di * wi) >>> FRACBITS;
          pi = (dr * wi + di * wr) >>> FRACBITS;
          macc_re[mb][j] = clampw(((mc == 0) ? 0 : macc_re[mb][j]) + pr, ACCLEN);
          macc_im[mb][j] = clampw(((mc == 0) ? 0 : macc_im[mb][j]) + pi, ACCLEN);
          ore = 16'(clampw(macc_re[mb][j], DATALEN));
          oim = 16'(clampw(macc_im[mb][j], DATALEN));
          ev1_d[j*CMPLXLEN +: CMPLXLEN] = {oim, ore};
        end
        ev1_v = (mc == mn - 1);
        ebusy = !(mb == NBEAT - 1 && mc == mn - 1);
        if (mb == NBEAT - 1) begin
          mb = 0;
          mc = (mc == mn - 1) ? 0 : mc + 1;
        end else begin
          mb = mb + 1;
        end
      end
    end
  end

  int                 out_cnt;
  int                 first_ov, last_ov, drive_first;
  logic [BEATLEN-1:0] last_out;

  always @(negedge clk) begin
    if (!rst) begin
      check("outvalid", BEATLEN'(bus.outvalid), BEATLEN'(ev2_v));
      if (ev2_v) check("outdata", bus.outdata, ev2_d);
      check("busy", BEATLEN'(bus.busy), BEATLEN'(ebusy));
      if (bus.outvalid === 1'b1) begin
        out_cnt++;
        last_out = bus.outdata;
        if (first_ov < 0) first_ov = cyc;
        last_ov = cyc;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_test();
    out_cnt = 0; first_ov = -1; last_ov = -1; drive_first = -1;
  endtask

  task automatic drive_beat(input logic [15:0] dre, input logic [15:0] dim,
                            input logic [15:0] wre, input logic [15:0] wim,
                            input logic [7:0] n);
    bus.invalid = 1'b1;
    bus.indata  = {NBIN{dim, dre}};
    bus.inwt    = {NBIN{wim, wre}};
    bus.nchnl   = n;
    if (drive_first < 0) drive_first = cyc;
    @(posedge clk);
    #1;
    bus.invalid = 1'b0;
  endtask

  task automatic drive_tile(input logic [15:0] dre, input logic [15:0] dim,
                            input logic [15:0] wre, input logic [15:0] wim,
                            input logic [7:0] n);
    for (int b = 0; b < NBEAT; b++) drive_beat(dre, dim, wre, wim, n);
  endtask

  initial begin
    rst = 1'b1;
    bus.invalid = 1'b0; bus.indata = '0; bus.inwt = '0; bus.nchnl = 8'd1;
    start_test();
    repeat (2) @(posedge clk);
    #1;
    check("reset_outvalid", BEATLEN'(bus.outvalid), '0);
    check("reset_outdata", bus.outdata, '0);
    check("reset_busy", BEATLEN'(bus.busy), '0);
    rst = 1'b0;
    idle(2);

    // Basic path
    start_test();
    drive_tile(16'h0100, 16'h0000, 16'h0100, 16'h0000, 8'd1);
    idle(4);
    check("basic_latency", BEATLEN'(first_ov - drive_first), BEATLEN'(2));
    check("basic_count", BEATLEN'(out_cnt), BEATLEN'(4));
    check("basic_re", BEATLEN'(last_out[15:0]), BEATLEN'(16'h0100));
    check("basic_im", BEATLEN'(last_out[31:16]), BEATLEN'(16'h0000));
    check("basic_busy_after", BEATLEN'(bus.busy), '0);

    // Complex product
    start_test();
    drive_tile(16'h0100, 16'h0200, 16'h0300, 16'h0400, 8'd1);
    idle(4);
    check("cplx_count", BEATLEN'(out_cnt), BEATLEN'(4));
`ifdef FREQ_MAC_CONJ_EN
    check("cplx_re", BEATLEN'(last_out[15:0]), BEATLEN'(16'h0B00));
    check("cplx_im", BEATLEN'(last_out[31:16]), BEATLEN'(16'h0200));
`else
    check("cplx_re", BEATLEN'(last_out[15:0]), BEATLEN'(16'hFB00));
    check("cplx_im", BEATLEN'(last_out[31:16]), BEATLEN'(16'h0A00));
`endif
    check("cplx_last_bin_re", BEATLEN'(last_out[BEATLEN-17 -: 16]), BEATLEN'(last_out[15:0]));

    // Accumulation over 3 channels, back to back
    start_test();
    drive_tile(16'h0100, 16'h0000, 16'h0100, 16'h0000, 8'd3);
    check("acc_busy_mid", BEATLEN'(bus.busy), BEATLEN'(1));
    drive_tile(16'h0100, 16'h0000, 16'h0100, 16'h0000, 8'd3);
    check("acc_no_early_out", BEATLEN'(out_cnt), '0);
    drive_tile(16'h0100, 16'h0000, 16'h0100, 16'h0000, 8'd3);
    idle(4);
    check("acc_count", BEATLEN'(out_cnt), BEATLEN'(4));
    check("acc_re", BEATLEN'(last_out[15:0]), BEATLEN'(16'h0300));

    // Saturation, positive and negative
    start_test();
    for (int c = 0; c < 4; c++) drive_tile(16'h7FFF, 16'h0000, 16'h7FFF, 16'h0000, 8'd4);
    idle(4);
    check("sat_pos_count", BEATLEN'(out_cnt), BEATLEN'(4));
    check("sat_pos_re", BEATLEN'(last_out[15:0]), BEATLEN'(16'h7FFF));
    start_test();
    for (int c = 0; c < 4; c++) drive_tile(16'h8000, 16'h0000, 16'h7FFF, 16'h0000, 8'd4);
    idle(4);
    check("sat_neg_re", BEATLEN'(last_out[15:0]), BEATLEN'(16'h8000));

    // nchnl=0 behaves as 1
    start_test();
    drive_tile(16'h0100, 16'h0000, 16'h0200, 16'h0000, 8'd0);
    idle(4);
    check("n0_count", BEATLEN'(out_cnt), BEATLEN'(4));
    check("n0_re", BEATLEN'(last_out[15:0]), BEATLEN'(16'h0200));

    // Gaps
    start_test();
    drive_beat(16'h0100, 16'h0000, 16'h0100, 16'h0000, 8'd1);
    drive_beat(16'h0100, 16'h0000, 16'h0100, 16'h0000, 8'd1);
    idle(3);
    drive_beat(16'h0100, 16'h0000, 16'h0100, 16'h0000, 8'd1);
    drive_beat(16'h0100, 16'h0000, 16'h0100, 16'h0000, 8'd1);
    idle(4);
    check("gap_count", BEATLEN'(out_cnt), BEATLEN'(4));
    check("gap_span", BEATLEN'(last_ov - first_ov), BEATLEN'(6));
    check("gap_re", BEATLEN'(last_out[15:0]), BEATLEN'(16'h0100));

    // Reset mid-group
    for (int b = 0; b < 3; b++) drive_beat(16'h0700, 16'h0000, 16'h0100, 16'h0000, 8'd2);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid_busy", BEATLEN'(bus.busy), '0);
    rst = 1'b0;
    idle(1);
    start_test();
    drive_tile(16'h0100, 16'h0000, 16'h0100, 16'h0000, 8'd2);
    drive_tile(16'h0100, 16'h0000, 16'h0100, 16'h0000, 8'd2);
    idle(4);
    check("rst_mid_count", BEATLEN'(out_cnt), BEATLEN'(4));
    check("rst_mid_re", BEATLEN'(last_out[15:0]), BEATLEN'(16'h0200));
    check("rst_mid_busy_after", BEATLEN'(bus.busy), '0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
